delay_cal_ctrl: RTL and testbench
=================================

# delay_cal_ctrl

Calibration sequencer for the 4-tap programmable input delay cell (DEL0..DEL3, 0.05 ns per step). On request it sweeps every tap code and checks a captured data bit against an expected bit at each setting. It then finds the widest contiguous run of error-free taps and parks the delay cell at the centre of that run. It sits between the I/O delay primitive and the interface training logic, and drives the delay control pins directly.

## Interface
Parameters:
- SETTLE_CYC, 4: CLK cycles waited after each tap change before sampling (≥1)
- SAMPLE_CNT, 16: compare cycles per tap (≥1)
- MAX_TAP, 15: highest tap code swept (1..15)

Ports:
- CLK  in  1  single clock for all logic
- RST  in  1  reset, synchronous, active-high
- START  in  1  begin calibration; honoured only in IDLE
- SMP  in  1  delayed data bit, already captured on CLK
- EXP  in  1  expected value of SMP for the same cycle
- DEL  out  4  tap code; bit i drives DELi of the delay cell
- BUSY  out  1  high from the cycle after START is accepted until the cycle after DONE
- DONE  out  1  one-cycle completion pulse
- LOCK  out  1  a passing window was found; valid from DONE until the next START
- ERR  out  1  no tap passed; valid from DONE until the next START
- WIN_LO  out  4  first tap of the chosen window
- WIN_HI  out  4  last tap of the chosen window

## Operation
- States: IDLE, SETTLE, SAMPLE, EVAL, FINISH.
- IDLE with START=1: tap←0, DEL←0, LOCK←0, ERR←0, clear window trackers, go to SETTLE. START in any other state is ignored.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: for SAMPLE_CNT cycles, set the sticky flag `fail` if SMP≠EXP on any cycle, then go to EVAL.
- EVAL (1 cycle) applies the run tracker:
  - pass: if cur_len=0 then cur_start←tap; cur_len←cur_len+1.
  - if the new cur_len > best_len, then best_lo←cur_start, best_len←new cur_len. A strict compare means that on a tie the lower window wins.
  - fail: cur_len←0.
  - then if tap<MAX_TAP: tap←tap+1, DEL←tap+1, clear `fail`, go to SETTLE; otherwise go to FINISH.
- FINISH (1 cycle), DONE=1:
  - best_len>0: LOCK←1, WIN_LO←best_lo, WIN_HI←best_lo+best_len−1, DEL←(WIN_LO+WIN_HI)>>1 (5-bit sum, floor).
  - best_len=0: ERR←1, WIN_LO←0, WIN_HI←0, DEL←0.
  - then go to IDLE.
- Widths: tap counter 4 bits; cur_len and best_len 5 bits (maximum 16); SETTLE/SAMPLE counter uses $clog2(max(SETTLE_CYC,SAMPLE_CNT)+1) bits.
- RST at any time forces IDLE and all outputs to their reset values, aborting any sweep in progress.

## Timing
- Reset values: DEL=0, BUSY=0, DONE=0, LOCK=0, ERR=0, WIN_LO=0, WIN_HI=0.
- START high at rising edge k gives:
  - SETTLE entered and BUSY=1 at k+1.
  - Each tap costs SETTLE_CYC+SAMPLE_CNT+1 cycles.
  - DONE=1 in cycle k+1+(MAX_TAP+1)·(SETTLE_CYC+SAMPLE_CNT+1). Defaults: k+337.
- Final DEL, LOCK, ERR and WIN_* become visible in the same cycle DONE is high. BUSY drops one cycle later.
- DEL changes only on the EVAL→SETTLE edge and in FINISH, so it is stable for the whole of every SETTLE+SAMPLE interval.
- START may be reasserted in the first IDLE cycle after FINISH.

## Structure
- Package delay_cal_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, EVAL, FINISH)
  - TAP_W=4
  - LEN_W=5
- Sub-module delay_cal_window implements the run tracker. Inputs: tap, pass, eval strobe, clear. Outputs: best_lo, best_len.
- The top level holds the FSM, the settle/sample counter and the output registers.

## Test plan
- SMP==EXP on every cycle, defaults -> DONE at k+337; LOCK=1, WIN_LO=0, WIN_HI=15, DEL=7.
- Mismatches injected outside taps 5..9 -> WIN_LO=5, WIN_HI=9, DEL=7, ERR=0.
- Passing taps 2..3 and 10..14 -> WIN_LO=10, WIN_HI=14, DEL=12. Tie case, passing taps 1..3 and 8..10 -> WIN_LO=1, WIN_HI=3, DEL=2.
- Mismatch on every tap, including one whose 16 samples have a single mismatch on sample 15 -> ERR=1, LOCK=0, DEL=0, WIN_*=0. The single-mismatch tap counts as a fail.
- Two scenarios covering START while BUSY and RST mid-sweep:
  - START pulsed at tap 6 -> ignored; DONE timing unchanged.
  - RST asserted during tap 6 SAMPLE -> next cycle all outputs at reset values, state IDLE; a fresh START then completes normally.
- SETTLE_CYC=1, SAMPLE_CNT=1, MAX_TAP=3, all pass -> DONE at k+13, WIN 0..3, DEL=1.

Source files
------------

// File: rtl/delay_cal_pkg.sv
// Shared definitions for the delay-cell calibration sequencer.
//   cal_state_t : sequencer states
//   TAP_W       : width of a tap code (4 taps -> DEL0..DEL3)
//   LEN_W       : width of a window length (must hold 16)
//   max_int     : helper for sizing the settle/sample down-counter
package delay_cal_pkg;

   localparam int TAP_W = 4;
   localparam int LEN_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      EVAL,
      FINISH
   } cal_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/delay_cal_ctrl_if.sv
// Handshake/result bundle between the interface training logic (master)
// and the calibration sequencer (slave).
//   START        : request a calibration sweep
//   SMP, EXP     : captured data bit and its expected value
//   DEL          : tap code driving the delay cell
//   BUSY, DONE   : sweep in progress / one-cycle completion pulse
//   LOCK, ERR    : sweep result flags
//   WIN_LO/WIN_HI: chosen passing window
interface delay_cal_ctrl_if;
   import delay_cal_pkg::*;

   logic             START;
   logic             SMP;
   logic             EXP;
   logic [TAP_W-1:0] DEL;
   logic             BUSY;
   logic             DONE;
   logic             LOCK;
   logic             ERR;
   logic [TAP_W-1:0] WIN_LO;
   logic [TAP_W-1:0] WIN_HI;

   modport master (
      output START, SMP, EXP,
      input  DEL, BUSY, DONE, LOCK, ERR, WIN_LO, WIN_HI
   );

   modport slave (
      input  START, SMP, EXP,
      output DEL, BUSY, DONE, LOCK, ERR, WIN_LO, WIN_HI
   );

endinterface

// File: rtl/delay_cal_window.sv
// Run tracker: finds the widest contiguous run of passing taps.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart tracking (start of a sweep)
//   eval     : apply the pass/fail result of the current tap
//   pass     : current tap was error-free
//   tap      : current tap code
//   best_lo  : first tap of the widest run so far
//   best_len : length of that run (0 = nothing passed)
// best_lo/best_len already include the tap being evaluated while eval is
// high, so the sequencer can latch the final result on the last EVAL edge.
module delay_cal_window
   import delay_cal_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             eval,
   input  logic             pass,
   input  logic [TAP_W-1:0] tap,
   output logic [TAP_W-1:0] best_lo,
   output logic [LEN_W-1:0] best_len
);

   logic [TAP_W-1:0] cur_start, cur_start_n, best_lo_q;
   logic [LEN_W-1:0] cur_len, cur_len_n, best_len_q;

   always_comb begin
      cur_start_n = cur_start;
      cur_len_n   = cur_len;
      best_lo     = best_lo_q;
      best_len    = best_len_q;
      if (eval) begin
         if (pass) begin
            if (cur_len == '0) begin
               cur_start_n = tap;
            end
            cur_len_n = cur_len + LEN_W'(1);
            // strict compare: on a tie the earlier (lower) run is kept
            if (cur_len_n > best_len_q) begin
               best_lo  = cur_start_n;
               best_len = cur_len_n;
            end
         end else begin
            cur_len_n = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cur_start  <= '0;
         cur_len    <= '0;
         best_lo_q  <= '0;
         best_len_q <= '0;
      end else begin
         cur_start  <= cur_start_n;
         cur_len    <= cur_len_n;
         best_lo_q  <= best_lo;
         best_len_q <= best_len;
      end
   end

endmodule

// File: rtl/delay_cal_ctrl.sv
// Calibration sequencer for the 4-tap programmable input delay cell.
// Sweeps tap codes 0..MAX_TAP, checks SMP against EXP for SAMPLE_CNT
// cycles after a SETTLE_CYC settling period at each tap, then parks DEL
// at the centre of the widest error-free run.
//   CLK  : clock
//   RST  : synchronous active-high reset
//   bus  : delay_cal_ctrl_if.slave (START/SMP/EXP in, DEL/BUSY/DONE/
//          LOCK/ERR/WIN_LO/WIN_HI out, all outputs registered)
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | waiting for START
// SETTLE | delay cell settling after a tap change
// SAMPLE | comparing SMP with EXP, sticky fail flag
// EVAL   | update run tracker, step to next tap or finish
// FINISH | DONE pulse, result outputs valid
module delay_cal_ctrl
   import delay_cal_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int SAMPLE_CNT = 16,
   parameter int MAX_TAP    = 15
) (
   input  logic            CLK,
   input  logic            RST,
   delay_cal_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(max_int(SETTLE_CYC, SAMPLE_CNT) + 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CNT - 1);
   localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(MAX_TAP);

   cal_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [TAP_W-1:0] tap;
   logic             fail;
   logic [TAP_W-1:0] del_q, win_lo_q, win_hi_q;
   logic             busy_q, done_q, lock_q, err_q;

   logic             win_clear, win_eval;
   logic [TAP_W-1:0] best_lo;
   logic [LEN_W-1:0] best_len;
   logic [LEN_W-1:0] hi_ext, mid_sum;

   assign win_clear = (state == IDLE) && bus.START;
   assign win_eval  = (state == EVAL);

   delay_cal_window u_window (
      .clk      (CLK),
      .rst      (RST),
      .clear    (win_clear),
      .eval     (win_eval),
      .pass     (!fail),
      .tap      (tap),
      .best_lo  (best_lo),
      .best_len (best_len)
   );

   // Window end and centre in 5 bits so a full 0..15 window cannot wrap.
   assign hi_ext  = LEN_W'(best_lo) + best_len - LEN_W'(1);
   assign mid_sum = LEN_W'(best_lo) + hi_ext;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         tap      <= '0;
         fail     <= 1'b0;
         del_q    <= '0;
         win_lo_q <= '0;
         win_hi_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         lock_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.START) begin
                  tap    <= '0;
                  del_q  <= '0;
                  lock_q <= 1'b0;
                  err_q  <= 1'b0;
                  fail   <= 1'b0;
                  busy_q <= 1'b1;
                  cnt    <= SETTLE_LD;
                  state  <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  cnt   <= SAMPLE_LD;
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            SAMPLE: begin
               if (bus.SMP != bus.EXP) begin
                  fail <= 1'b1;
               end
               if (cnt == '0) begin
                  state <= EVAL;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            EVAL: begin
               if (tap < LAST_TAP) begin
                  tap   <= tap + TAP_W'(1);
                  del_q <= tap + TAP_W'(1);
                  fail  <= 1'b0;
                  cnt   <= SETTLE_LD;
                  state <= SETTLE;
               end else begin
                  done_q <= 1'b1;
                  state  <= FINISH;
                  if (best_len != '0) begin
                     lock_q   <= 1'b1;
                     win_lo_q <= best_lo;
                     win_hi_q <= TAP_W'(hi_ext);
                     del_q    <= TAP_W'(mid_sum >> 1);
                  end else begin
                     err_q    <= 1'b1;
                     win_lo_q <= '0;
                     win_hi_q <= '0;
                     del_q    <= '0;
                  end
               end
            end
            FINISH: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.DEL    = del_q;
   assign bus.BUSY   = busy_q;
   assign bus.DONE   = done_q;
   assign bus.LOCK   = lock_q;
   assign bus.ERR    = err_q;
   assign bus.WIN_LO = win_lo_q;
   assign bus.WIN_HI = win_hi_q;

endmodule

// File: tb/tb_delay_cal_ctrl.sv
// Testbench for delay_cal_ctrl: randomized sweeps checked every cycle
// against a cycle-count based model of the sequence, plus literal
// expectations for the documented scenarios and a small-parameter instance.
module tb_delay_cal_ctrl;

   localparam int S     = 4;
   localparam int N     = 16;
   localparam int M     = 15;
   localparam int P     = S + N + 1;
   localparam int TOTAL = (M + 1) * P;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   delay_cal_ctrl_if bus ();
   delay_cal_ctrl_if bus2 ();

   delay_cal_ctrl #(.SETTLE_CYC(S), .SAMPLE_CNT(N), .MAX_TAP(M)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   delay_cal_ctrl #(.SETTLE_CYC(1), .SAMPLE_CNT(1), .MAX_TAP(3)) dut_small (
      .CLK (clk),
      .RST (rst),
      .bus (bus2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_n counts edges since the accepting edge; tap and phase follow from it.
   bit        m_busy = 1'b0;
   int        m_n = 0;
   bit [15:0] m_fail = '0;
   int        m_del = 0, m_lo = 0, m_hi = 0;
   bit        m_done = 1'b0, m_lock = 1'b0, m_err = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_lock = 0; m_err = 0;
         m_del = 0; m_lo = 0; m_hi = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (bus.START === 1'b1) begin
               m_busy = 1; m_n = 0; m_fail = '0;
               m_del = 0; m_lock = 0; m_err = 0;
            end
         end else begin
            int ph, tp;
            m_n++;
            ph = (m_n - 1) % P;
            tp = (m_n - 1) / P;
            if (ph >= S && ph < S + N && bus.SMP !== bus.EXP) m_fail[tp] = 1'b1;
            if (m_n < TOTAL) begin
               m_del = m_n / P;
            end else if (m_n == TOTAL) begin
               int best_lo, best_len;
               best_lo = 0; best_len = 0;
               for (int a = 0; a <= M; a++) begin
                  int l;
                  l = 0;
                  while (a + l <= M && !m_fail[a + l]) l++;
                  if (l > best_len) begin best_len = l; best_lo = a; end
               end
               m_done = 1;
               if (best_len > 0) begin
                  m_lock = 1; m_lo = best_lo; m_hi = best_lo + best_len - 1;
                  m_del = (m_lo + m_hi) / 2;
               end else begin
                  m_err = 1; m_lo = 0; m_hi = 0; m_del = 0;
               end
            end else begin
               m_busy = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("DEL",    bus.DEL,    m_del);
         chk("BUSY",   bus.BUSY,   m_busy);
         chk("DONE",   bus.DONE,   m_done);
         chk("LOCK",   bus.LOCK,   m_lock);
         chk("ERR",    bus.ERR,    m_err);
         chk("WIN_LO", bus.WIN_LO, m_lo);
         chk("WIN_HI", bus.WIN_HI, m_hi);
      end
   end

   // ---------------- stimulus ----------------
   // mask bit t = 1: tap t passes. single_tap: failing tap whose only
   // mismatch lands on the last sample. Called #1 after an edge in IDLE.
   task automatic run_sweep(input logic [15:0] mask, input int single_tap,
                            input bit poke_start, input bit poke_rst, input bit lit,
                            input int e_lo, input int e_hi, input int e_del,
                            input int e_lock, input int e_err);
      int t, p, bad;
      bit mis;
      bad = 0;
      bus.START = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0;
      chk("busy_after_start", bus.BUSY, 1);
      for (int j = 0; j < TOTAL; j++) begin
         t = j / P;
         p = j % P;
         if (p == 0) bad = (t == single_tap) ? N - 1 : int'($urandom_range(0, N - 1));
         bus.EXP = 1'($urandom_range(0, 1));
         if (p >= S && p < S + N) mis = !mask[t] && (p - S == bad);
         else mis = 1'($urandom_range(0, 1));
         bus.SMP = bus.EXP ^ mis;
         bus.START = poke_start && t == 6 && (p == 2 || p == S + 3);
         if (poke_rst && t == 6 && p == S + 5) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            bus.START = 1'b0;
            chk("rst_DEL",    bus.DEL,    0);
            chk("rst_BUSY",   bus.BUSY,   0);
            chk("rst_DONE",   bus.DONE,   0);
            chk("rst_LOCK",   bus.LOCK,   0);
            chk("rst_ERR",    bus.ERR,    0);
            chk("rst_WIN_LO", bus.WIN_LO, 0);
            chk("rst_WIN_HI", bus.WIN_HI, 0);
            return;
         end
         @(posedge clk); #1;
      end
      bus.START = 1'b0;
      chk("done_timing", bus.DONE, 1);
      if (lit) begin
         chk("lit_WIN_LO", bus.WIN_LO, e_lo);
         chk("lit_WIN_HI", bus.WIN_HI, e_hi);
         chk("lit_DEL",    bus.DEL,    e_del);
         chk("lit_LOCK",   bus.LOCK,   e_lock);
         chk("lit_ERR",    bus.ERR,    e_err);
      end
      @(posedge clk); #1;
      chk("busy_drop", bus.BUSY, 0);
      chk("done_pulse", bus.DONE, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rm;
      int cnt;
      bus.START = 0; bus.SMP = 0; bus.EXP = 0;
      bus2.START = 0; bus2.SMP = 0; bus2.EXP = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_DEL",  bus.DEL,  0);
      chk("reset_BUSY", bus.BUSY, 0);
      chk("reset_LOCK", bus.LOCK, 0);
      chk("reset_WIN_HI", bus.WIN_HI, 0);
      @(posedge clk); #1;

      run_sweep(16'hFFFF, -1, 0, 0, 1, 0, 15, 7, 1, 0);
      run_sweep(16'h03E0, -1, 0, 0, 1, 5, 9, 7, 1, 0);
      run_sweep(16'h7C0C, -1, 0, 0, 1, 10, 14, 12, 1, 0);
      run_sweep(16'h070E, -1, 0, 0, 1, 1, 3, 2, 1, 0);
      run_sweep(16'h0000, 4, 0, 0, 1, 0, 0, 0, 0, 1);
      rm = 16'($urandom());
      run_sweep(rm, -1, 1, 0, 0, 0, 0, 0, 0, 0);
      rm = 16'($urandom());
      run_sweep(rm, -1, 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         rm = 16'($urandom()) | 16'($urandom());
         run_sweep(rm, -1, 0, 0, 0, 0, 0, 0, 0, 0);
      end

      // small configuration, all pass
      bus2.START = 1'b1;
      @(posedge clk); #1;
      bus2.START = 1'b0;
      cnt = 0;
      while (bus2.DONE !== 1'b1 && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("small_done_timing", cnt, 12);
      chk("small_LOCK",   bus2.LOCK,   1);
      chk("small_ERR",    bus2.ERR,    0);
      chk("small_WIN_LO", bus2.WIN_LO, 0);
      chk("small_WIN_HI", bus2.WIN_HI, 3);
      chk("small_DEL",    bus2.DEL,    1);
      chk("small_BUSY",   bus2.BUSY,   1);
      @(posedge clk); #1;
      chk("small_busy_drop", bus2.BUSY, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
